// File: rtl/mcif_wrr_arbn_pkg.sv
// Shared constants for the MCIF weighted round-robin arbiter family.
// Every arbiter block imports these rather than keeping its own copy.
package mcif_wrr_arbn_pkg;

  localparam int MCIF_ARB_MAX_CH     = 32;
  localparam int MCIF_ARB_DEF_WGT_W  = 4;

endpackage

// File: rtl/mcif_rr_pick_n.sv
// Rotating-priority search: returns the first set bit of req, starting at
// start+1 and wrapping so that start itself is examined last.
module mcif_rr_pick_n #(
  parameter int NUM_CH = 8,
  parameter int ID_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [ID_W-1:0]   start,
  output logic              found,
  output logic [ID_W-1:0]   idx
);

  int pos;

  always_comb begin
    found = 1'b0;
    idx   = start;
    pos   = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      pos = (int'(start) + k) % NUM_CH;
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = pos[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mcif_wrr_arbn.sv
// Weighted round-robin arbiter with zero-cycle grant, per-owner transfer
// credit, and a lock that pins the owner while a transfer is stalled.
//
// Handshake: a transfer completes on a cycle where gnt_valid & gnt_ready;
// gnt_valid & ~gnt_ready means the owner has an attempt pending and keeps
// the grant (lock) until it completes, whatever arb_req does meanwhile.
module mcif_wrr_arbn
  import mcif_wrr_arbn_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int WGT_W  = MCIF_ARB_DEF_WGT_W,
  parameter int ID_W   = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       arb_req,
  input  logic [NUM_CH*WGT_W-1:0] arb_wgt,
  input  logic                    gnt_valid,
  input  logic                    gnt_ready,
  output logic [NUM_CH-1:0]       arb_gnt,
  output logic [ID_W-1:0]         gnt_id,
  output logic                    gnt_any
);

  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic [WGT_W-1:0]  credit_q, credit_d;
  logic              lock_q, lock_d;

  logic              pick_found;
  logic [ID_W-1:0]   pick_id;
  logic [ID_W-1:0]   nxt_id;
  logic              new_grant;
  logic [NUM_CH-1:0] nxt_onehot;
  logic [WGT_W-1:0]  wgt_raw;
  logic [WGT_W-1:0]  wgt_eff;
  logic              xfer;

  mcif_rr_pick_n #(
    .NUM_CH (NUM_CH),
    .ID_W   (ID_W)
  ) u_pick (
    .req   (arb_req),
    .start (cur_id_q),
    .found (pick_found),
    .idx   (pick_id)
  );

  always_comb begin
    nxt_id    = cur_id_q;
    new_grant = 1'b0;
    if (!lock_q && !(arb_req[cur_id_q] && (credit_q != '0)) && pick_found) begin
      nxt_id    = pick_id;
      new_grant = 1'b1;
    end
  end

  // A locked owner keeps its grant even after dropping its request.
  always_comb begin
    nxt_onehot         = '0;
    nxt_onehot[nxt_id] = 1'b1;
    arb_gnt            = nxt_onehot & (arb_req | {NUM_CH{lock_q}});
  end

  assign gnt_id  = nxt_id;
  assign gnt_any = |arb_gnt;

  assign wgt_raw = arb_wgt[nxt_id*WGT_W +: WGT_W];
  assign wgt_eff = (wgt_raw == '0) ? WGT_W'(1) : wgt_raw;

  // Handshakes seen with no grant out only move the lock flop.
  assign xfer = gnt_valid & gnt_ready & gnt_any;

  always_comb begin
    cur_id_d = nxt_id;
    credit_d = credit_q;
    lock_d   = lock_q;
    if (new_grant) begin
      credit_d = xfer ? (wgt_eff - WGT_W'(1)) : wgt_eff;
    end else if (xfer && (credit_q != '0)) begin
      credit_d = credit_q - WGT_W'(1);
    end
    if (gnt_valid && !gnt_ready) begin
      lock_d = 1'b1;
    end else if (gnt_valid && gnt_ready) begin
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_id_q <= '0;
      credit_q <= '0;
      lock_q   <= 1'b0;
    end else begin
      cur_id_q <= cur_id_d;
      credit_q <= credit_d;
      lock_q   <= lock_d;
    end
  end

endmodule
